fog_loop_sequencer: RTL and testbench



---
 rtl/fog_loop_pkg.sv | 29 ++
 rtl/fog_loop_sequencer_qual.sv | 47 ++++
 rtl/fog_loop_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fog_loop_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fog_loop_pkg.sv
// fog_loop_pkg
// Shared types and helpers for the FOG closed-loop sequencer.
//   state_t     : sequencer state encoding (IDLE/SETTLE/ACQ/TRACK)
//   GAIN_W_DEF  : default gain-select code width
//   CNT_W_DEF   : default qualification / relock counter width
//   abs_sat()   : two's-complement magnitude, saturating the most negative value
package fog_loop_pkg;

  localparam int GAIN_W_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACQ    = 3'd2,
    ST_TRACK  = 3'd3
  } state_t;

  // -2^31 has no positive counterpart in 32 bits; clamp it to 2^31-1.
  function automatic logic [31:0] abs_sat(input logic [31:0] v);
    if (v == 32'h8000_0000)
      return 32'h7fff_ffff;
    else if (v[31])
      return (~v) + 32'd1;
    else
      return v;
  endfunction

endpackage

// File: rtl/fog_loop_sequencer_qual.sv
// fog_consec_qual
// Counts consecutive strobes on which the condition holds and pulses hit on
// the strobe that brings the run up to the target. A strobe with the
// condition false restarts the run; a hit restarts it as well.
//   i_clk, i_rst_n : clock, async active-low reset
//   strobe         : evaluation strobe
//   condition      : event qualifier, sampled with strobe
//   target         : required run length (0 behaves as 1)
//   clear          : holds the run count at zero and suppresses hit
//   hit            : combinational pulse in the qualifying strobe cycle
module fog_consec_qual #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             strobe,
  input  logic             condition,
  input  logic [CNT_W-1:0] target,
  input  logic             clear,
  output logic             hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] eff_target;

  assign eff_target = (target == '0) ? ONE : target;
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + ONE;
  // >= rather than == so that lowering the target mid-run still qualifies.
  assign hit        = strobe & condition & ~clear & (cnt_inc >= eff_target);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (strobe) begin
      if (!condition || hit)
        cnt <= '0;
      else
        cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/fog_loop_sequencer.sv
// fog_loop_sequencer
// Sequences FOG feedback bring-up: settle with feedback off, high-gain
// acquisition with gain step-down, locked tracking, and re-acquisition on
// loss of lock. The filtered error is evaluated once per i_trig.
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_trig, i_err   : evaluation strobe and signed filtered error
//   i_fb_req        : CPU closed-loop request (level)
//   i_settle_trig   : trigs to wait in SETTLE
//   i_lock_th       : |err| <= th is a good trig
//   i_unlock_th     : |err| >  th is a bad trig
//   i_lock_cnt      : good trigs per gain step
//   i_unlock_cnt    : bad trigs before re-acquisition
//   i_gain_acq/trk  : starting / final gain-select codes
//   o_fb_on, o_gain_sel, o_state, o_locked, o_relock_cnt : registered outputs
//
// state  | meaning
// IDLE   | feedback off, gain preloaded with i_gain_acq
// SETTLE | feedback off, counting trigs before closing the loop
// ACQ    | feedback on, stepping gain down on each qualified run
// TRACK  | feedback on at tracking gain, watching for loss of lock
module fog_loop_sequencer
  import fog_loop_pkg::*;
#(
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_trig,
  input  logic [31:0]       i_err,
  input  logic              i_fb_req,
  input  logic [CNT_W-1:0]  i_settle_trig,
  input  logic [31:0]       i_lock_th,
  input  logic [31:0]       i_unlock_th,
  input  logic [CNT_W-1:0]  i_lock_cnt,
  input  logic [CNT_W-1:0]  i_unlock_cnt,
  input  logic [GAIN_W-1:0] i_gain_acq,
  input  logic [GAIN_W-1:0] i_gain_trk,
  output logic              o_fb_on,
  output logic [GAIN_W-1:0] o_gain_sel,
  output logic [2:0]        o_state,
  output logic              o_locked,
  output logic [CNT_W-1:0]  o_relock_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1);

  state_t            state, state_nxt;
  logic [GAIN_W-1:0] gain, gain_nxt;
  logic [CNT_W-1:0]  settle_cnt, settle_nxt, settle_inc;
  logic [CNT_W-1:0]  relock, relock_nxt;
  logic              fb_on_nxt, locked_nxt;
  logic [31:0]       err_abs;
  logic              good, bad, good_hit, bad_hit;
  logic              in_acq, in_track;

  assign err_abs  = abs_sat(i_err);
  assign good     = (err_abs <= i_lock_th);
  assign bad      = (err_abs > i_unlock_th);
  assign in_acq   = (state == ST_ACQ);
  assign in_track = (state == ST_TRACK);

  // Clearing on a dropped request masks any hit in the same cycle, which
  // gives the fallback priority over trig-driven transitions.
  fog_consec_qual #(.CNT_W(CNT_W)) u_good_qual (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .strobe    (i_trig & in_acq),
    .condition (good),
    .target    (i_lock_cnt),
    .clear     (~in_acq | ~i_fb_req),
    .hit       (good_hit)
  );

  fog_consec_qual #(.CNT_W(CNT_W)) u_bad_qual (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .strobe    (i_trig & in_track),
    .condition (bad),
    .target    (i_unlock_cnt),
    .clear     (~in_track | ~i_fb_req),
    .hit       (bad_hit)
  );

  assign settle_inc = (settle_cnt == '1) ? settle_cnt : settle_cnt + CNT_ONE;

  always_comb begin
    state_nxt  = state;
    gain_nxt   = gain;
    settle_nxt = settle_cnt;
    relock_nxt = relock;

    if (state == ST_IDLE)
      gain_nxt = i_gain_acq;

    if (!i_fb_req) begin
      state_nxt  = ST_IDLE;
      settle_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          settle_nxt = '0;
          state_nxt  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (i_settle_trig == '0) begin
            state_nxt  = ST_ACQ;
            settle_nxt = '0;
          end else if (i_trig) begin
            if (settle_inc >= i_settle_trig) begin
              state_nxt  = ST_ACQ;
              settle_nxt = '0;
            end else begin
              settle_nxt = settle_inc;
            end
          end
        end
        ST_ACQ: begin
          if (good_hit) begin
            if (gain < i_gain_trk)
              gain_nxt = gain + GAIN_ONE;
            else
              state_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (bad_hit) begin
            state_nxt = ST_ACQ;
            gain_nxt  = i_gain_acq;
            if (relock != '1)
              relock_nxt = relock + CNT_ONE;
          end
        end
        default: begin
          state_nxt  = ST_IDLE;
          settle_nxt = '0;
        end
      endcase
    end

    fb_on_nxt  = (state_nxt == ST_ACQ) || (state_nxt == ST_TRACK);
    locked_nxt = (state_nxt == ST_TRACK);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      gain       <= '0;
      settle_cnt <= '0;
      relock     <= '0;
      o_fb_on    <= 1'b0;
      o_locked   <= 1'b0;
    end else begin
      state      <= state_nxt;
      gain       <= gain_nxt;
      settle_cnt <= settle_nxt;
      relock     <= relock_nxt;
      o_fb_on    <= fb_on_nxt;
      o_locked   <= locked_nxt;
    end
  end

  assign o_state      = state;
  assign o_gain_sel   = gain;
  assign o_relock_cnt = relock;

endmodule

// File: tb/tb_fog_loop_sequencer.sv
// tb_fog_loop_sequencer
// Directed scenarios for fog_loop_sequencer. Each stimulus step pushes the
// hand-computed output snapshot it expects, tagged with the cycle in which it
// must appear; a negedge monitor pops and compares independently.
module tb_fog_loop_sequencer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_trig;
  logic [31:0] i_err;
  logic        i_fb_req;
  logic [15:0] i_settle_trig;
  logic [31:0] i_lock_th;
  logic [31:0] i_unlock_th;
  logic [15:0] i_lock_cnt;
  logic [15:0] i_unlock_cnt;
  logic [3:0]  i_gain_acq;
  logic [3:0]  i_gain_trk;
  logic        o_fb_on;
  logic [3:0]  o_gain_sel;
  logic [2:0]  o_state;
  logic        o_locked;
  logic [15:0] o_relock_cnt;

  fog_loop_sequencer #(.GAIN_W(4), .CNT_W(16)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_trig        (i_trig),
    .i_err         (i_err),
    .i_fb_req      (i_fb_req),
    .i_settle_trig (i_settle_trig),
    .i_lock_th     (i_lock_th),
    .i_unlock_th   (i_unlock_th),
    .i_lock_cnt    (i_lock_cnt),
    .i_unlock_cnt  (i_unlock_cnt),
    .i_gain_acq    (i_gain_acq),
    .i_gain_trk    (i_gain_trk),
    .o_fb_on       (o_fb_on),
    .o_gain_sel    (o_gain_sel),
    .o_state       (o_state),
    .o_locked      (o_locked),
    .o_relock_cnt  (o_relock_cnt)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_ACQ = 3'd2, S_TRACK = 3'd3;
  localparam logic [31:0] NEG_MAX = 32'h8000_0000;

  typedef struct {
    string       name;
    int unsigned due;
    logic [24:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: compare every snapshot that has come due.
  always @(negedge i_clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      n_checks++;
      if ({o_fb_on, o_gain_sel, o_state, o_locked, o_relock_cnt} === cur.v)
        n_pass++;
      else
        $display("FAIL %s: got fb=%b gain=%0d state=%0d locked=%b relock=%0d, want fb=%b gain=%0d state=%0d locked=%b relock=%0d",
                 cur.name, o_fb_on, o_gain_sel, o_state, o_locked, o_relock_cnt,
                 cur.v[24], cur.v[23:20], cur.v[19:17], cur.v[16], cur.v[15:0]);
    end
  end

  task automatic push(input string name, input int unsigned lag, input logic fb,
                      input logic [3:0] g, input logic [2:0] st, input logic lk,
                      input logic [15:0] rl);
    exp_t e;
    e.name = name;
    e.due  = cyc + lag;
    e.v    = {fb, g, st, lk, rl};
    sb.push_back(e);
  endtask

  task automatic drive(input logic trig, input logic [31:0] err, input logic req);
    @(posedge i_clk);
    #1;
    i_trig   = trig;
    i_err    = err;
    i_fb_req = req;
  endtask

  // One trig followed by a quiet cycle; expectation is for the cycle after the trig.
  task automatic trig(input string name, input logic [31:0] err, input logic req,
                      input logic fb, input logic [3:0] g, input logic [2:0] st,
                      input logic lk, input logic [15:0] rl);
    drive(1'b1, err, req);
    push(name, 1, fb, g, st, lk, rl);
    drive(1'b0, 32'd0, req);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n       = 1'b0;
    i_trig        = 1'b0;
    i_err         = '0;
    i_fb_req      = 1'b0;
    i_settle_trig = 16'd3;
    i_lock_th     = 32'd20;
    i_unlock_th   = 32'd100;
    i_lock_cnt    = 16'd2;
    i_unlock_cnt  = 16'd3;
    i_gain_acq    = 4'd1;
    i_gain_trk    = 4'd4;

    // Reset and bring-up
    drive(1'b0, 32'd0, 1'b0);
    push("reset_hold", 1, 1'b0, 4'd0, S_IDLE, 1'b0, 16'd0);
    drive(1'b0, 32'd0, 1'b0);
    i_rst_n = 1'b1;
    push("idle_gain_load", 1, 1'b0, 4'd1, S_IDLE, 1'b0, 16'd0);
    drive(1'b0, 32'd0, 1'b1);
    push("req_rise", 1, 1'b0, 4'd1, S_SETTLE, 1'b0, 16'd0);

    trig("settle_t1", 32'd10, 1'b1, 1'b0, 4'd1, S_SETTLE, 1'b0, 16'd0);
    trig("settle_t2", 32'd10, 1'b1, 1'b0, 4'd1, S_SETTLE, 1'b0, 16'd0);
    trig("settle_t3", 32'd10, 1'b1, 1'b1, 4'd1, S_ACQ,    1'b0, 16'd0);

    trig("acq_t1", 32'd10, 1'b1, 1'b1, 4'd1, S_ACQ,   1'b0, 16'd0);
    trig("acq_t2", 32'd10, 1'b1, 1'b1, 4'd2, S_ACQ,   1'b0, 16'd0);
    trig("acq_t3", 32'd10, 1'b1, 1'b1, 4'd2, S_ACQ,   1'b0, 16'd0);
    trig("acq_t4", 32'd10, 1'b1, 1'b1, 4'd3, S_ACQ,   1'b0, 16'd0);
    trig("acq_t5", 32'd10, 1'b1, 1'b1, 4'd3, S_ACQ,   1'b0, 16'd0);
    trig("acq_t6", 32'd10, 1'b1, 1'b1, 4'd4, S_ACQ,   1'b0, 16'd0);
    trig("acq_t7", 32'd10, 1'b1, 1'b1, 4'd4, S_ACQ,   1'b0, 16'd0);
    trig("acq_t8", 32'd10, 1'b1, 1'b1, 4'd4, S_TRACK, 1'b1, 16'd0);
    n_checks++;
    if (o_state === S_TRACK && o_locked === 1'b1 && o_fb_on === 1'b1)
      n_pass++;
    else
      $display("FAIL direct_track: state=%0d locked=%b fb=%b", o_state, o_locked, o_fb_on);

    // Loss of lock, with one in-band trig restarting the bad run
    trig("unlock_b1",  NEG_MAX, 1'b1, 1'b1, 4'd4, S_TRACK, 1'b1, 16'd0);
    trig("unlock_b2",  NEG_MAX, 1'b1, 1'b1, 4'd4, S_TRACK, 1'b1, 16'd0);
    trig("unlock_ok",  32'd50,  1'b1, 1'b1, 4'd4, S_TRACK, 1'b1, 16'd0);
    trig("unlock_b3",  NEG_MAX, 1'b1, 1'b1, 4'd4, S_TRACK, 1'b1, 16'd0);
    trig("unlock_b4",  NEG_MAX, 1'b1, 1'b1, 4'd4, S_TRACK, 1'b1, 16'd0);
    trig("unlock_exit", NEG_MAX, 1'b1, 1'b1, 4'd1, S_ACQ,  1'b0, 16'd1);
    n_checks++;
    if (o_relock_cnt === 16'd1 && o_gain_sel === 4'd1 && o_state === S_ACQ)
      n_pass++;
    else
      $display("FAIL direct_unlock: relock=%0d gain=%0d state=%0d", o_relock_cnt, o_gain_sel, o_state);

    // Lock interrupted: -20 is on the good boundary, -25 is not
    i_lock_cnt = 16'd4;
    trig("intr_g1",   32'd10,         1'b1, 1'b1, 4'd1, S_ACQ, 1'b0, 16'd1);
    trig("intr_g2",   32'd10,         1'b1, 1'b1, 4'd1, S_ACQ, 1'b0, 16'd1);
    trig("intr_g3",   -32'sd20,       1'b1, 1'b1, 4'd1, S_ACQ, 1'b0, 16'd1);
    trig("intr_bad",  -32'sd25,       1'b1, 1'b1, 4'd1, S_ACQ, 1'b0, 16'd1);
    trig("intr_r1",   32'd10,         1'b1, 1'b1, 4'd1, S_ACQ, 1'b0, 16'd1);
    trig("intr_r2",   32'd10,         1'b1, 1'b1, 4'd1, S_ACQ, 1'b0, 16'd1);
    trig("intr_r3",   32'd10,         1'b1, 1'b1, 4'd1, S_ACQ, 1'b0, 16'd1);
    trig("intr_step", 32'd10,         1'b1, 1'b1, 4'd2, S_ACQ, 1'b0, 16'd1);

    // Request drop on a qualifying trig
    trig("drop_g1",   32'd10, 1'b1, 1'b1, 4'd2, S_ACQ,  1'b0, 16'd1);
    trig("drop_g2",   32'd10, 1'b1, 1'b1, 4'd2, S_ACQ,  1'b0, 16'd1);
    trig("drop_g3",   32'd10, 1'b1, 1'b1, 4'd2, S_ACQ,  1'b0, 16'd1);
    trig("drop_fall", 32'd10, 1'b0, 1'b0, 4'd2, S_IDLE, 1'b0, 16'd1);
    n_checks++;
    if (o_state === S_IDLE && o_fb_on === 1'b0 && o_gain_sel === 4'd2)
      n_pass++;
    else
      $display("FAIL direct_drop: state=%0d fb=%b gain=%0d", o_state, o_fb_on, o_gain_sel);

    // Degenerate settings
    i_settle_trig = 16'd0;
    i_lock_cnt    = 16'd0;
    i_gain_acq    = 4'd5;
    i_gain_trk    = 4'd2;
    push("degen_idle", 1, 1'b0, 4'd5, S_IDLE, 1'b0, 16'd1);
    drive(1'b0, 32'd0, 1'b1);
    push("degen_settle", 1, 1'b0, 4'd5, S_SETTLE, 1'b0, 16'd1);
    drive(1'b0, 32'd0, 1'b1);
    push("degen_acq", 1, 1'b1, 4'd5, S_ACQ, 1'b0, 16'd1);
    trig("degen_track", 32'd0, 1'b1, 1'b1, 4'd5, S_TRACK, 1'b1, 16'd1);

    // Asynchronous reset in the middle of TRACK, checked before the next edge
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    push("async_reset", 0, 1'b0, 4'd0, S_IDLE, 1'b0, 16'd0);
    #1;
    n_checks++;
    if (o_relock_cnt === 16'd0 && o_state === S_IDLE && o_fb_on === 1'b0 &&
        o_locked === 1'b0 && o_gain_sel === 4'd0)
      n_pass++;
    else
      $display("FAIL direct_async_reset: relock=%0d state=%0d fb=%b locked=%b gain=%0d",
               o_relock_cnt, o_state, o_fb_on, o_locked, o_gain_sel);
    drive(1'b0, 32'd0, 1'b1);
    i_rst_n = 1'b1;
    push("post_reset", 1, 1'b0, 4'd5, S_SETTLE, 1'b0, 16'd0);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_checks++;
      $display("FAIL %s: expectation never compared (due cycle %0d, now %0d)", cur.name, cur.due, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
